// File: rtl/spi_slave_rx_param.sv
// Oversampling SPI slave receiver, all four CPOL/CPHA modes, back-to-back words, truncated-frame flag.
// Optional transmit path (holding + shift register on miso) is built when SPI_SLAVE_TX_EN is defined.
module spi_slave_rx_param #(
  parameter int DATA_W      = 12,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int MSB_FIRST   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic              sync_clock,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic [DATA_W-1:0] dout,
  output logic              done,
  output logic              frame_err,
  output logic              busy,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_load,
  output logic              tx_ready
);

  localparam int CW = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);
  localparam logic IDLE_CLK = (CPOL != 0);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                   state;
  logic [SYNC_STAGES-1:0]   sclk_sync, cs_sync, mosi_sync;
  logic                     sclk_prev;
  logic                     sclk_s, cs_s, mosi_s;
  logic                     rise, fall, lead, trail, sample_edge;
  logic [CW-1:0]            bit_cnt, cnt_after;
  logic                     wrap;
  logic [DATA_W-1:0]        sr, sr_next;
  logic                     done_pend, err_pend;

  always_ff @(posedge sync_clock) begin
    if (rst) begin
      sclk_sync <= {SYNC_STAGES{IDLE_CLK}};
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_prev <= IDLE_CLK;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_prev <= sclk_s;
    end
  end

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  assign rise        = sclk_s & ~sclk_prev;
  assign fall        = ~sclk_s & sclk_prev;
  assign lead        = IDLE_CLK ? fall : rise;
  assign trail       = IDLE_CLK ? rise : fall;
  assign sample_edge = (CPHA == 0) ? lead : trail;

  // Bit count as it will stand after this cycle's sample edge, so a coincident cs_n rise sees the wrap.
  always_comb begin
    cnt_after = bit_cnt;
    wrap      = 1'b0;
    if (sample_edge) begin
      if (bit_cnt == LAST) begin
        cnt_after = '0;
        wrap      = 1'b1;
      end else begin
        cnt_after = bit_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    if (MSB_FIRST != 0) sr_next = {sr[DATA_W-2:0], mosi_s};
    else                sr_next = {mosi_s, sr[DATA_W-1:1]};
  end

  always_ff @(posedge sync_clock) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      sr        <= '0;
      dout      <= '0;
      done_pend <= 1'b0;
      err_pend  <= 1'b0;
      done      <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      done      <= done_pend;
      frame_err <= err_pend;
      done_pend <= 1'b0;
      err_pend  <= 1'b0;
      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (!cs_s) begin
            state   <= SHIFT;
            busy    <= 1'b1;
            bit_cnt <= '0;
            sr      <= '0;
          end
        end
        SHIFT: begin
          if (sample_edge) begin
            sr      <= sr_next;
            bit_cnt <= cnt_after;
            if (wrap) begin
              dout      <= sr_next;
              done_pend <= 1'b1;
            end
          end
          if (cs_s) begin
            state <= IDLE;
            busy  <= 1'b0;
            if (cnt_after != '0) err_pend <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SPI_SLAVE_TX_EN
  logic [DATA_W-1:0] tx_hold, tx_sr, load_word;
  logic              tx_skip, miso_q, word_start, shift_edge;

  function automatic logic head(input logic [DATA_W-1:0] v);
    return (MSB_FIRST != 0) ? v[DATA_W-1] : v[0];
  endfunction

  function automatic logic [DATA_W-1:0] adv(input logic [DATA_W-1:0] v);
    return (MSB_FIRST != 0) ? {v[DATA_W-2:0], 1'b0} : {1'b0, v[DATA_W-1:1]};
  endfunction

  assign shift_edge = (CPHA == 0) ? trail : lead;
  assign word_start = !cs_s && ((state == IDLE) || (state == SHIFT && wrap));
  assign load_word  = tx_ready ? '0 : tx_hold;

  // With CPHA=0 a wrap happens on the leading edge; the following trailing edge must not
  // advance past the first bit of the new word, hence tx_skip.
  always_ff @(posedge sync_clock) begin
    if (rst) begin
      tx_hold  <= '0;
      tx_sr    <= '0;
      tx_ready <= 1'b1;
      tx_skip  <= 1'b0;
      miso_q   <= 1'b0;
    end else begin
      if (word_start) begin
        tx_ready <= 1'b1;
        if (CPHA == 0) begin
          miso_q  <= head(load_word);
          tx_sr   <= adv(load_word);
          tx_skip <= (state == SHIFT);
        end else begin
          tx_sr   <= load_word;
          tx_skip <= 1'b0;
        end
      end else if (state == SHIFT && shift_edge) begin
        if (tx_skip) begin
          tx_skip <= 1'b0;
        end else begin
          miso_q <= head(tx_sr);
          tx_sr  <= adv(tx_sr);
        end
      end
      if (tx_load && tx_ready) begin
        tx_hold  <= tx_data;
        tx_ready <= 1'b0;
      end
      if (cs_s) miso_q <= 1'b0;
    end
  end

  assign miso = miso_q;
`else
  logic unused_tx;
  assign unused_tx = ^{tx_data, tx_load};
  assign miso      = 1'b0;
  assign tx_ready  = 1'b0;
`endif

endmodule
